// File: rtl/zap_wb_burst_sram_pkg.sv
// zap_wb_burst_sram_pkg: Wishbone cycle-type encodings and FSM states for the burst SRAM.
package zap_wb_burst_sram_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/zap_wb_ram_lfsr.sv
// zap_wb_ram_lfsr: seeded 16-bit Fibonacci LFSR (taps 16,14,13,11) with an advance enable.
module zap_wb_ram_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset)
            value <= SEED;
        else if (en)
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end

endmodule

// File: rtl/zap_wb_burst_sram.sv
// zap_wb_burst_sram: Wishbone B3 slave SRAM with classic and incrementing-burst cycles.
// Define ZAP_WB_RAM_STALL_EN to compile in LFSR-driven pseudo-random wait states.
module zap_wb_burst_sram
    import zap_wb_burst_sram_pkg::*;
#(
    parameter int          SIZE_IN_BYTES = 32768,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic [31:0] i_wb_adr,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_cti,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack
);

    localparam int AW    = $clog2(SIZE_IN_BYTES);
    localparam int IW    = AW - 2;
    localparam int DEPTH = SIZE_IN_BYTES / 4;

    logic [31:0]   mem [DEPTH];
    state_t        state, state_n;
    logic [IW-1:0] idx, fetch_idx;
    logic [31:0]   fetch_dat;
    logic          req, stall, fetch, wr;

    assign idx      = i_wb_adr[AW-1:2];
    assign req      = i_wb_cyc & i_wb_stb;
    assign o_wb_ack = (state != IDLE) & ~stall;
    assign wr       = req & i_wb_we & o_wb_ack & ~i_reset;

    logic unused_adr;
    assign unused_adr = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};

`ifdef ZAP_WB_RAM_STALL_EN
    logic [15:0] lfsr;

    zap_wb_ram_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (i_clk),
        .reset (i_reset),
        .en    (1'b1),
        .value (lfsr)
    );

    assign stall = lfsr[0];

    logic unused_lfsr;
    assign unused_lfsr = ^lfsr[15:1];
`else
    assign stall = 1'b0;

    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
`endif

    // A stalled beat holds state and data; an abort exits even while stalled.
    always_comb begin
        state_n   = state;
        fetch     = 1'b0;
        fetch_idx = idx;
        case (state)
            IDLE: begin
                fetch   = req;
                state_n = !req ? IDLE : (i_wb_cti == CTI_INCR) ? BURST : RESP;
            end
            RESP:
                state_n = stall ? RESP : IDLE;
            BURST: begin
                fetch     = req & ~stall & (i_wb_cti == CTI_INCR);
                fetch_idx = idx + IW'(1);
                state_n   = !req ? IDLE : stall ? BURST : (i_wb_cti == CTI_INCR) ? BURST : IDLE;
            end
            default:
                state_n = IDLE;
        endcase
    end

    // Forward same-cycle write lanes so a prefetch never returns stale bytes.
    always_comb begin
        fetch_dat = mem[fetch_idx];
        for (int b = 0; b < 4; b++)
            if (wr && i_wb_sel[b] && fetch_idx == idx)
                fetch_dat[8*b +: 8] = i_wb_dat[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++)
            if (wr && i_wb_sel[b])
                mem[idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            o_wb_dat <= '0;
        end else begin
            state <= state_n;
            if (fetch)
                o_wb_dat <= fetch_dat;
        end
    end

endmodule

// File: tb/tb_zap_wb_burst_sram.sv
// tb_zap_wb_burst_sram: scoreboard bench for classic, byte-lane, burst, alias and reset-abort accesses.
`timescale 1ns/1ps
module tb_zap_wb_burst_sram;
    import zap_wb_burst_sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [2:0]  cti = CTI_CLASSIC;
    logic [3:0]  sel = '0;
    logic [31:0] rdat;
    logic        ack;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q [$];
    logic [31:0] wbuf [64];

    always #5 clk = ~clk;

    zap_wb_burst_sram #(.SIZE_IN_BYTES(32768), .LFSR_SEED(16'hACE1)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .i_wb_adr (adr),
        .i_wb_we  (we),
        .i_wb_cti (cti),
        .i_wb_sel (sel),
        .i_wb_dat (wdat),
        .o_wb_dat (rdat),
        .o_wb_ack (ack)
    );

`ifdef ZAP_WB_RAM_STALL_EN
    logic [15:0] mlfsr;
    always @(posedge clk)
        mlfsr <= rst ? 16'hACE1 : {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
`endif

    task automatic run(input logic w, input logic [31:0] base, input int n, input logic [3:0] s,
                       input logic classic, input string name);
        int beat = 0;
        int cycles = 0;
        int stalls = 0;
        logic [31:0] e;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s;
        while (beat < n && cycles < 1000) begin
            adr  = base + 32'(4 * beat);
            cti  = classic ? CTI_CLASSIC : (beat == n - 1) ? CTI_EOB : CTI_INCR;
            wdat = wbuf[beat];
            @(negedge clk);
            cycles++;
`ifdef ZAP_WB_RAM_STALL_EN
            if (cycles > 1) begin
                stalls += int'(mlfsr[0]);
                checks++;
                if (ack !== !mlfsr[0]) $display("FAIL %s_stall_ack: ack %b want %b", name, ack, !mlfsr[0]);
                else passes++;
            end
`endif
            if (ack) begin
                if (!w) begin
                    e = 'x;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    checks++;
                    if (rdat !== e) $display("FAIL %s_data[%0d]: got %h want %h", name, beat, rdat, e);
                    else passes++;
                end
                beat++;
            end
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        checks++;
        if (beat != n) $display("FAIL %s_beats: got %0d want %0d", name, beat, n);
        else passes++;
        checks++;
        if (cycles != n + 1 + stalls) $display("FAIL %s_cycles: got %0d want %0d", name, cycles, n + 1 + stalls);
        else passes++;
    endtask

    task automatic check_gap(input string name);
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) $display("FAIL %s_gap: ack %b want 0", name, ack);
        else passes++;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string name);
        wbuf[0] = d;
        run(1'b1, a, 1, s, 1'b1, name);
    endtask

    task automatic rd1(input logic [31:0] a, input logic [31:0] e, input string name);
        exp_q.push_back(e);
        run(1'b0, a, 1, 4'hF, 1'b1, name);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack);
        else passes++;
        checks++;
        if (rdat !== 32'h0) $display("FAIL reset_dat: got %h want 00000000", rdat);
        else passes++;
    endtask

    task automatic test_classic;
        wr1(32'h100, 32'hDEADBEEF, 4'hF, "classic_wr");
        check_gap("classic_wr");
        rd1(32'h100, 32'hDEADBEEF, "classic_rd");
        check_gap("classic_rd");
    endtask

    task automatic test_byte_lane;
        wr1(32'h100, 32'h11223344, 4'hF, "lane_base");
        wr1(32'h101, 32'h0000AA00, 4'b0010, "lane_wr");
        rd1(32'h100, 32'h1122AA44, "lane_rd");
        wr1(32'h100, 32'hFFFFFFFF, 4'b0000, "lane_nop");
        rd1(32'h100, 32'h1122AA44, "lane_nop_rd");
    endtask

    task automatic test_burst;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i);
        run(1'b1, 32'h200, 4, 4'hF, 1'b0, "burst_wr");
        check_gap("burst_wr");
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        run(1'b0, 32'h200, 4, 4'hF, 1'b0, "burst_rd");
        check_gap("burst_rd");
    endtask

    task automatic test_alias;
        wr1(32'h8004, 32'hCAFEF00D, 4'hF, "alias_wr");
        rd1(32'h0004, 32'hCAFEF00D, "alias_rd");
    endtask

    task automatic test_reset_burst;
        int beat = 0;
        int cycles = 0;
        for (int i = 0; i < 4; i++) wr1(32'h300 + 32'(4 * i), 32'h55550000 + 32'(i), 4'hF, "rb_pre");
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0000000 + 32'(i);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        while (beat < 2 && cycles < 1000) begin
            adr  = 32'h300 + 32'(4 * beat);
            cti  = CTI_INCR;
            wdat = wbuf[beat];
            @(negedge clk);
            cycles++;
            if (ack) beat++;
            @(posedge clk); #1;
        end
        adr = 32'h308; wdat = wbuf[2]; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        @(negedge clk);
        checks++;
        if (beat != 2) $display("FAIL rb_beats: got %0d want 2", beat);
        else passes++;
        checks++;
        if (ack !== 1'b0) $display("FAIL rb_ack: got %b want 0", ack);
        else passes++;
        rd1(32'h300, 32'hA0000000, "rb_rd0");
        rd1(32'h304, 32'hA0000001, "rb_rd1");
        rd1(32'h308, 32'h55550002, "rb_rd2");
        rd1(32'h30C, 32'h55550003, "rb_rd3");
    endtask

    task automatic test_long_burst;
        for (int i = 0; i < 64; i++) wbuf[i] = {16'hA5A5, 16'(i * 3)};
        run(1'b1, 32'h1000, 64, 4'hF, 1'b0, "long_wr");
        for (int i = 0; i < 64; i++) exp_q.push_back({16'hA5A5, 16'(i * 3)});
        run(1'b0, 32'h1000, 64, 4'hF, 1'b0, "long_rd");
        check_gap("long_rd");
    endtask

    initial begin
        test_reset;
        test_classic;
        test_byte_lane;
        test_burst;
        test_alias;
        test_reset_burst;
        test_long_burst;
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
